// File: rtl/noc_packet_arbiter.sv
// noc_packet_arbiter: packet-granular round-robin arbiter that steers one of
// NUM_REQ local requesters onto one of two router input VCs and holds the
// grant/VC lock (wormhole) until the tail flit handshakes.
// Optional watchdog: define NOC_ARB_WATCHDOG_EN to build the stall counter and
// the sticky arb_timeout flag; otherwise arb_timeout is tied low.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no packet in flight; arbitrate header flits, pick a free VC
// ST_BUSY | grant/VC locked; flits of the granted requester pass through

`ifndef Noc_Data_Width
`define Noc_Data_Width 32
`endif

module noc_packet_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int PTR_W          = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                               noc_clk,
  input  logic                               noc_rst_n,
  input  logic [NUM_REQ-1:0]                 req_valid,
  output logic [NUM_REQ-1:0]                 req_ready,
  input  logic [NUM_REQ*`Noc_Data_Width-1:0] req_flit,
  input  logic [NUM_REQ-1:0]                 req_is_header,
  input  logic [NUM_REQ-1:0]                 req_is_tail,
  output logic                               Noc_sender_channel0_valid,
  input  logic                               Noc_sender_channel0_ready,
  output logic [`Noc_Data_Width-1:0]         Noc_sender_channel0_flit,
  input  logic                               Noc_sender_channel0_VCready,
  output logic                               Noc_sender_channel0_is_header,
  output logic                               Noc_sender_channel0_is_tail,
  output logic                               Noc_sender_channel1_valid,
  input  logic                               Noc_sender_channel1_ready,
  output logic [`Noc_Data_Width-1:0]         Noc_sender_channel1_flit,
  input  logic                               Noc_sender_channel1_VCready,
  output logic                               Noc_sender_channel1_is_header,
  output logic                               Noc_sender_channel1_is_tail,
  output logic                               arb_busy,
  output logic                               arb_timeout
);

  localparam int W = `Noc_Data_Width;

  // Reject parameter sets the pointer arithmetic cannot handle.
  if (NUM_REQ < 2 || NUM_REQ > 8 || PTR_W != $clog2(NUM_REQ) || TIMEOUT_CYCLES < 1)
  begin : g_bad_param
    $error("noc_packet_arbiter: unsupported parameter set");
  end

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [PTR_W-1:0]   r_grant;
  logic               r_vc_sel;
  logic [PTR_W-1:0]   r_rr_ptr;

  logic [NUM_REQ-1:0] w_cand;
  logic [PTR_W-1:0]   w_scan;
  logic [PTR_W-1:0]   w_winner;
  logic               w_found;
  logic [PTR_W-1:0]   w_rr_nxt;
  logic               w_vc_ok;
  logic               w_vc_pick;
  logic               w_take;

  logic [NUM_REQ-1:0] w_gnt_oh;
  logic               w_g_valid;
  logic               w_g_hdr;
  logic               w_g_tail;
  logic [W-1:0]       w_g_flit;
  logic               w_g_ready;
  logic               w_hs;

  assign w_cand    = req_valid & req_is_header;
  assign w_vc_ok   = Noc_sender_channel0_VCready | Noc_sender_channel1_VCready;
  assign w_vc_pick = ~Noc_sender_channel0_VCready;
  assign w_take    = (r_state == ST_IDLE) & w_found & w_vc_ok;
  assign w_rr_nxt  = (w_winner == PTR_W'(NUM_REQ-1)) ? '0 : w_winner + 1'b1;

  // Round-robin scan: first header-presenting requester at or after rr_ptr.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_scan   = r_rr_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && w_cand[w_scan]) begin
        w_found  = 1'b1;
        w_winner = w_scan;
      end
      w_scan = (w_scan == PTR_W'(NUM_REQ-1)) ? '0 : w_scan + 1'b1;
    end
  end

  // Mux the granted requester's flit and sideband out of the flat bus.
  always_comb begin
    w_gnt_oh  = '0;
    w_g_valid = 1'b0;
    w_g_hdr   = 1'b0;
    w_g_tail  = 1'b0;
    w_g_flit  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant == PTR_W'(i)) begin
        w_gnt_oh[i] = 1'b1;
        w_g_valid   = req_valid[i];
        w_g_hdr     = req_is_header[i];
        w_g_tail    = req_is_tail[i];
        w_g_flit    = req_flit[i*W +: W];
      end
    end
  end

  assign w_g_ready = r_vc_sel ? Noc_sender_channel1_ready : Noc_sender_channel0_ready;
  assign w_hs      = (r_state == ST_BUSY) & w_g_valid & w_g_ready;
  assign arb_busy  = (r_state == ST_BUSY);

  // State register plus grant/VC/pointer capture at arbitration time.
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      r_state  <= ST_IDLE;
      r_grant  <= '0;
      r_vc_sel <= 1'b0;
      r_rr_ptr <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_take) begin
        r_grant  <= w_winner;
        r_vc_sel <= w_vc_pick;
        r_rr_ptr <= w_rr_nxt;
      end
    end
  end

  // Next state and combinational steering; VCready is only looked at in IDLE.
  always_comb begin
    w_state_nxt                   = r_state;
    req_ready                     = '0;
    Noc_sender_channel0_valid     = 1'b0;
    Noc_sender_channel0_flit      = '0;
    Noc_sender_channel0_is_header = 1'b0;
    Noc_sender_channel0_is_tail   = 1'b0;
    Noc_sender_channel1_valid     = 1'b0;
    Noc_sender_channel1_flit      = '0;
    Noc_sender_channel1_is_header = 1'b0;
    Noc_sender_channel1_is_tail   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_take) w_state_nxt = ST_BUSY;
      end
      ST_BUSY: begin
        req_ready = w_gnt_oh & {NUM_REQ{w_g_ready}};
        if (!r_vc_sel) begin
          Noc_sender_channel0_valid     = w_g_valid;
          Noc_sender_channel0_flit      = w_g_flit;
          Noc_sender_channel0_is_header = w_g_hdr;
          Noc_sender_channel0_is_tail   = w_g_tail;
        end else begin
          Noc_sender_channel1_valid     = w_g_valid;
          Noc_sender_channel1_flit      = w_g_flit;
          Noc_sender_channel1_is_header = w_g_hdr;
          Noc_sender_channel1_is_tail   = w_g_tail;
        end
        if (w_hs && w_g_tail) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

`ifdef NOC_ARB_WATCHDOG_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_stall_cnt;
  logic             r_timeout;

  // Count consecutive stalled BUSY cycles; the flag is sticky until reset.
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      r_stall_cnt <= '0;
      r_timeout   <= 1'b0;
    end else begin
      if (r_state != ST_BUSY || w_hs) begin
        r_stall_cnt <= '0;
      end else if (r_stall_cnt != CNT_W'(TIMEOUT_CYCLES)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (r_stall_cnt == CNT_W'(TIMEOUT_CYCLES)) r_timeout <= 1'b1;
    end
  end

  assign arb_timeout = r_timeout;
`else
  assign arb_timeout = 1'b0;
`endif

endmodule
